// File: rtl/asroba_div_seq.sv
// asroba_div_seq -- sequential approximate signed divider.
//
// The divisor magnitude is rounded to the nearest power of two, yr = 2^k.
// The quotient is approximated as |x| * m / yr^2. With TAYLOR=1,
// m = 2*yr - |y|, which is a first-order correction of |x|/yr. With
// TAYLOR=0, m = yr. The product is formed by a shift-add multiplier that
// handles one multiplier bit per cycle. Magnitudes use the one's-complement
// convention shared by the ASROBA multipliers.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operands x/y valid (taken only while in_ready=1)
//   in_ready   block is idle and can accept operands
//   x, y       signed dividend / divisor
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts result
//   q          signed approximate quotient
//   dbz        divide-by-zero flag, qualified by out_valid
module asroba_div_seq #(
    parameter int unsigned TAYLOR = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic        dbz
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_MUL,
        S_NORM,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [15:0] xa_q, xa_d;
    logic        s_q, s_d;
    logic [3:0]  k_q, k_d;
    logic [16:0] m_q, m_d;
    logic        dbzi_q, dbzi_d;
    logic [31:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;
    logic [15:0] q_q, q_d;
    logic        dbz_q, dbz_d;

    logic [15:0] ya_c;
    logic [3:0]  p_c;
    logic [3:0]  k_c;
    logic [16:0] yr_c;
    logic [16:0] m_c;
    logic [31:0] sh_c;
    logic [15:0] qa_c;

    // Operand preparation and the normalising shift.
    always_comb begin
        ya_c = y_q ^ {16{y_q[15]}};
        p_c  = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (ya_c[i]) begin
                p_c = 4'(i);
            end
        end
        // Round up when the bit below the MSB is set (only for p >= 2).
        // ya[15] is always 0, so p <= 14 and k fits in 4 bits.
        if ((p_c >= 4'd2) && ya_c[p_c - 4'd1]) begin
            k_c = p_c + 4'd1;
        end else begin
            k_c = p_c;
        end
        yr_c = 17'd1 << k_c;
        if (TAYLOR != 0) begin
            m_c = (yr_c << 1) - {1'b0, ya_c};
        end else begin
            m_c = yr_c;
        end
        // Dividing by yr^2 is a right shift by 2k.
        sh_c = acc_q >> {k_q, 1'b0};
        qa_c = (sh_c > 32'h0000_7FFF) ? 16'h7FFF : sh_c[15:0];
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        xa_d        = xa_q;
        s_d         = s_q;
        k_d         = k_q;
        m_d         = m_q;
        dbzi_d      = dbzi_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_d         = q_q;
        dbz_d       = dbz_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d        = x;
                    y_d        = y;
                    in_ready_d = 1'b0;
                    state_d    = S_PREP;
                end
            end
            S_PREP: begin
                xa_d    = x_q ^ {16{x_q[15]}};
                s_d     = x_q[15] ^ y_q[15];
                k_d     = k_c;
                m_d     = m_c;
                dbzi_d  = (ya_c == 16'd0);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                if (m_q[cnt_q]) begin
                    acc_d = acc_q + ({16'd0, xa_q} << cnt_q);
                end
                if (cnt_q == 5'd16) begin
                    state_d = S_NORM;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_NORM: begin
                // A divide-by-zero result carries no sign.
                q_d         = dbzi_q ? 16'h7FFF : (qa_c ^ {16{s_q}});
                dbz_d       = dbzi_q;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            xa_q        <= '0;
            s_q         <= 1'b0;
            k_q         <= '0;
            m_q         <= '0;
            dbzi_q      <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            xa_q        <= xa_d;
            s_q         <= s_d;
            k_q         <= k_d;
            m_q         <= m_d;
            dbzi_q      <= dbzi_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;
    assign dbz       = dbz_q;

endmodule

// File: doc/asroba_div_seq.md
Name: asroba_div_seq

Overview:
- Sequential approximate signed divider; the inverse operation companion to the ASROBA rounding-based approximate multiplier, sharing its arithmetic conventions.
- Divisor magnitude rounded to nearest power of two yr = 2^k; quotient ≈ |x|·(2·yr − |y|) / yr², a first-order Taylor correction of |x|/yr.
- Correction product computed by a shift-add multiplier, one bit per cycle.
- Sits beside the ASROBA multipliers in the logarithmic approximate arithmetic library; valid/ready on both sides.

Parameters:
TAYLOR, 1, 1 = corrected quotient (m = 2·yr − |y|); 0 = pure power-of-two division (m = yr, result = |x| >> k)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
x  input  16  signed dividend
y  input  16  signed divisor
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
q  output  16  signed approximate quotient
dbz  output  1  divide-by-zero flag, qualified by out_valid

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: in_ready=1, out_valid=0, q=0, dbz=0; FSM in IDLE; all datapath registers cleared.
- Rst asserted in any state, including mid-MUL, aborts the operation. The result is discarded, with no partial output.
- Sign handling (codebase one's-complement convention):
  - xa = x ^ {16{x[15]}}; ya = y ^ {16{y[15]}}; s = x[15] ^ y[15].
  - Final q = qa ^ {16{s}}.
- Rounding of ya, with p = MSB index of ya:
  - If p ≥ 2 and ya[p−1] = 1, then k = p+1.
  - Otherwise k = p.
  - yr = 2^k; k ranges 0..15.
- Multiplier operand: m = 2·yr − ya when TAYLOR=1, otherwise m = yr. m is 17 bits wide.
- Product P = xa·m, 32 bits unsigned, computed LSB-first over exactly 17 cycles. Each cycle: if m[i] then acc += xa << i.
- Normalise:
  - qa = P >> (2k), truncating.
  - If qa > 0x7FFF, saturate to 0x7FFF.
- Divide-by-zero: ya == 0 (y = 0 or y = 0xFFFF).
  - Result q = 16'h7FFF with no sign applied; dbz = 1.
  - Latency is identical to the normal path; the MUL state still runs with its result ignored.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch x and y (edge E0) and go to PREP.
  - PREP: compute xa, ya, s, k, m, dbz; clear acc. Edge E1 → MUL.
  - MUL: 17 cycles, edges E2..E18; a 5-bit counter runs 0..16. On count 16 → NORM.
  - NORM: shift, saturate, apply sign, load q/dbz, set out_valid. Edge E19 → DONE.
  - DONE: out_valid=1; q and dbz are held stable while out_ready=0. On out_valid && out_ready → IDLE, out_valid=0.
- Latency: out_valid is high after E0+19 edges.
- in_ready is low from E0 until the cycle after result acceptance. There is no back-to-back overlap and no input buffering.
- in_valid while in_ready=0 is ignored; the x and y inputs are don't-care outside IDLE.
- out_ready is ignored outside DONE.
- Throughput: one operation per ≥20 cycles.

Test Plan:
- Reset: drive rst=1 → in_ready=1, out_valid=0, q=0, dbz=0. Assert rst during a MUL cycle, then release → no out_valid; the next op completes normally.
- Exact and rounding cases, TAYLOR=1:
  - x=1000, y=1 → q=1000.
  - y=3 (k=1, no round-up) → q=250.
  - y=6 (yr=8, m=10) → q=156.
  - x=12000, y=100 (yr=128, m=156) → q=114.
  - Each with dbz=0 and out_valid exactly 19 edges after acceptance.
- Sign: x=−1000 (0xFC18), y=6 → xa=999, P=9990 → qa=156 → q=0xFF63. Also x=1000, y=−6 (ya=5, yr=4, m=3, P=3000 >> 4 = 187) → q=~187=0xFF44.
- Divide-by-zero: y=0 and y=0xFFFF with x=−5 → q=0x7FFF, dbz=1, same latency.
- Backpressure: hold out_ready=0 for 10 cycles → q/dbz stable, in_ready=0, new in_valid ignored. Raise out_ready → accepted; in_ready=1 the next cycle.
- TAYLOR=0 instance: x=1000, y=6 → q=125 (1000 >> 3). x=32767, y=1 → q=32767.
